// File: rtl/rr_fifo_arbiter.sv
// Round-robin merger of up to 8 FWFT source FIFOs into one FWFT stream through a 2-entry registered buffer.
// Optional build macro RR_ARB_SRC_TAG_EN: stored word bits 31:29 carry the granted source index.
module rr_fifo_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [N_SRC-1:0]     SRC_EMPTY,
  input  logic [32*N_SRC-1:0]  SRC_DATA,
  output logic [N_SRC-1:0]     SRC_READ,
  input  logic [N_SRC-1:0]     SRC_ENABLE,
  output logic                 OUT_EMPTY,
  output logic [31:0]          OUT_DATA,
  input  logic                 OUT_READ,
  output logic [7:0]           READ_ERROR_CNT
);

  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] mem [2];
  logic [2:0]  last_grant;
  logic [7:0]  err_cnt;

  logic [7:0]  cand_ext;
  logic        grant_vld;
  logic [2:0]  grant;
  logic [31:0] sel_word;
  logic [31:0] push_word;
  logic        pop;

  // Cyclic search starting one past the last grant; the search only looks at
  // registered count, so OUT_READ never reaches SRC_READ combinationally.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    cand_ext = '0;
    cand_ext[N_SRC-1:0] = ~SRC_EMPTY & SRC_ENABLE;
    grant_vld = 1'b0;
    grant     = last_grant;
    sum       = '0;
    idx       = '0;
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      sum = {1'b0, last_grant} + 4'(off);
      if (sum >= 4'(N_SRC)) idx = 3'(sum - 4'(N_SRC));
      else                  idx = sum[2:0];
      if (!grant_vld && cand_ext[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
    if (RST || count == 2'd2) grant_vld = 1'b0;
  end

  always_comb begin
    logic [7:0] rd_ext;
    rd_ext = '0;
    if (grant_vld) rd_ext[grant] = 1'b1;
    SRC_READ = rd_ext[N_SRC-1:0];
  end

  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant == 3'(i)) sel_word = SRC_DATA[32*i +: 32];
    end
`ifdef RR_ARB_SRC_TAG_EN
    push_word = {grant, sel_word[28:0]};
`else
    push_word = sel_word;
`endif
  end

  assign pop            = OUT_READ && (count != 2'd0);
  assign OUT_EMPTY      = (count == 2'd0);
  assign OUT_DATA       = mem[rd_ptr];
  assign READ_ERROR_CNT = err_cnt;

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      mem[0]     <= '0;
      mem[1]     <= '0;
      last_grant <= 3'(N_SRC - 1);
      err_cnt    <= '0;
    end else begin
      if (grant_vld) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
        last_grant  <= grant;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(grant_vld) - 2'(pop);
      if (OUT_READ && count == 2'd0 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Self-checking bench for rr_fifo_arbiter: directed vector table plus queue-based reference model.
module tb_rr_fifo_arbiter;
  localparam int N = 4;

  logic            BUS_CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    SRC_EMPTY = '1;
  logic [32*N-1:0] SRC_DATA = '0;
  logic [N-1:0]    SRC_READ;
  logic [N-1:0]    SRC_ENABLE = '1;
  logic            OUT_EMPTY;
  logic [31:0]     OUT_DATA;
  logic            OUT_READ = 1'b0;
  logic [7:0]      READ_ERROR_CNT;

  rr_fifo_arbiter #(.N_SRC(N)) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .SRC_EMPTY(SRC_EMPTY), .SRC_DATA(SRC_DATA),
    .SRC_READ(SRC_READ), .SRC_ENABLE(SRC_ENABLE), .OUT_EMPTY(OUT_EMPTY),
    .OUT_DATA(OUT_DATA), .OUT_READ(OUT_READ), .READ_ERROR_CNT(READ_ERROR_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  emp;
    logic [3:0]  en;
    logic        rd;
    logic [3:0]  exp_rd;
    logic        exp_oe;
    logic        chk_d;
    logic [31:0] exp_d;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t tbl [15];

  // Reference model: source FIFOs and output buffer as queues.
  logic [31:0] srcq [N][$];
  logic [31:0] mbuf [$];
  int          lg;
  int          merr;
  int          dut_pops [N];

  task automatic model_reset();
    mbuf.delete();
    lg   = N - 1;
    merr = 0;
  endtask

  task automatic clear_pops();
    for (int i = 0; i < N; i++) dut_pops[i] = 0;
  endtask

  task automatic step(input logic rst, input logic [N-1:0] en, input logic rd);
    int g;
    int s;
    logic [N-1:0] er;
    logic [31:0] w;
    RST = rst;
    SRC_ENABLE = en;
    OUT_READ = rd;
    for (int i = 0; i < N; i++) begin
      SRC_EMPTY[i] = (srcq[i].size() == 0);
      SRC_DATA[32*i +: 32] = (srcq[i].size() != 0) ? srcq[i][0] : 32'h0;
    end
    @(negedge BUS_CLK);
    g = -1;
    if (!rst && mbuf.size() < 2) begin
      for (int off = 1; off <= N; off++) begin
        s = (lg + off) % N;
        if (g < 0 && en[s] && srcq[s].size() != 0) g = s;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("src_read", 32'(SRC_READ), 32'(er));
    chk("out_empty", 32'(OUT_EMPTY), 32'(mbuf.size() == 0));
    if (mbuf.size() != 0) chk("out_data", OUT_DATA, mbuf[0]);
    chk("err_cnt", 32'(READ_ERROR_CNT), 32'(merr));
    for (int i = 0; i < N; i++) dut_pops[i] += int'(SRC_READ[i]);
    if (rst) model_reset();
    else begin
      if (rd) begin
        if (mbuf.size() != 0) void'(mbuf.pop_front());
        else if (merr < 255) merr++;
      end
      if (g >= 0) begin
        w = srcq[g].pop_front();
`ifdef RR_ARB_SRC_TAG_EN
        w[31:29] = 3'(g);
`endif
        mbuf.push_back(w);
        lg = g;
      end
    end
    @(posedge BUS_CLK);
    #1;
  endtask

  initial begin
    int total;
    logic [N-1:0] en;

    //        rst emp   en    rd  exp_rd oe chkd data           err
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0000_0000, 8'd0};
    tbl[1]  = '{1'b0, 4'hE, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0, 32'h0000_0000, 8'd0};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1, 32'h1234_5678, 8'd0};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 32'h1234_5678, 8'd0};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 8'd0};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 8'd0};
    tbl[6]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 8'd1};
    tbl[7]  = '{1'b0, 4'h0, 4'hA, 1'b0, 4'h2, 1'b1, 1'b0, 32'h0000_0000, 8'd1};
    tbl[8]  = '{1'b0, 4'h0, 4'hA, 1'b0, 4'h8, 1'b0, 1'b1, 32'h2000_1111, 8'd1};
    tbl[9]  = '{1'b0, 4'h0, 4'hA, 1'b0, 4'h0, 1'b0, 1'b1, 32'h2000_1111, 8'd1};
    tbl[10] = '{1'b0, 4'h0, 4'hA, 1'b1, 4'h0, 1'b0, 1'b1, 32'h2000_1111, 8'd1};
    tbl[11] = '{1'b0, 4'h0, 4'hA, 1'b1, 4'h2, 1'b0, 1'b1, 32'h6000_3333, 8'd1};
    tbl[12] = '{1'b0, 4'h0, 4'hA, 1'b0, 4'h8, 1'b0, 1'b1, 32'h2000_1111, 8'd1};
    tbl[13] = '{1'b1, 4'h0, 4'hA, 1'b0, 4'h0, 1'b0, 1'b1, 32'h2000_1111, 8'd1};
    tbl[14] = '{1'b0, 4'h0, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 32'h0000_0000, 8'd0};

    // Source words carry their index in bits 31:29 so tagging leaves them unchanged.
    SRC_DATA = {32'h6000_3333, 32'h4000_2222, 32'h2000_1111, 32'h1234_5678};
    RST = 1'b1;
    repeat (2) @(posedge BUS_CLK);
    #1;
    for (int r = 0; r < 15; r++) begin
      RST        = tbl[r].rst;
      SRC_EMPTY  = tbl[r].emp;
      SRC_ENABLE = tbl[r].en;
      OUT_READ   = tbl[r].rd;
      @(negedge BUS_CLK);
      chk($sformatf("vec%0d_src_read", r), 32'(SRC_READ), 32'(tbl[r].exp_rd));
      chk($sformatf("vec%0d_out_empty", r), 32'(OUT_EMPTY), 32'(tbl[r].exp_oe));
      if (tbl[r].chk_d) chk($sformatf("vec%0d_out_data", r), OUT_DATA, tbl[r].exp_d);
      chk($sformatf("vec%0d_err_cnt", r), 32'(READ_ERROR_CNT), 32'(tbl[r].exp_err));
      @(posedge BUS_CLK);
      #1;
    end

    // Resynchronise DUT and model.
    RST = 1'b1;
    OUT_READ = 1'b0;
    @(posedge BUS_CLK);
    #1;
    model_reset();

    // Round robin, all sources busy, consumer always reading.
    for (int i = 0; i < N; i++) for (int k = 0; k < 5; k++) srcq[i].push_back({3'(i), 29'(k * 16 + i + 1)});
    clear_pops();
    for (int c = 0; c < 12; c++) step(1'b0, '1, 1'b1);
    for (int i = 0; i < N; i++) chk($sformatf("rr_pops_src%0d", i), 32'(dut_pops[i]), 32'd3);

    // Backpressure: two pops fill the buffer, then one pulse frees one slot.
    step(1'b1, '1, 1'b0);
    clear_pops();
    for (int c = 0; c < 6; c++) step(1'b0, '1, 1'b0);
    total = 0;
    for (int i = 0; i < N; i++) total += dut_pops[i];
    chk("bp_pops", 32'(total), 32'd2);
    clear_pops();
    step(1'b0, '1, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, '1, 1'b0);
    total = 0;
    for (int i = 0; i < N; i++) total += dut_pops[i];
    chk("bp_pulse_pops", 32'(total), 32'd1);

    // Error counter saturation with all sources empty.
    for (int i = 0; i < N; i++) srcq[i].delete();
    step(1'b1, '1, 1'b0);
    for (int c = 0; c < 300; c++) step(1'b0, '1, 1'b1);
    chk("err_sat", 32'(READ_ERROR_CNT), 32'h0000_00FF);

    // Randomised traffic against the model.
    step(1'b1, '1, 1'b0);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (srcq[i].size() < 4 && $urandom_range(1, 0) == 1) srcq[i].push_back($urandom);
      en = ($urandom_range(3, 0) == 0) ? N'($urandom) : '1;
      step(($urandom_range(199, 0) == 0), en, ($urandom_range(9, 0) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_fifo_arbiter.md
Name: rr_fifo_arbiter

Overview:
- Round-robin merger that collects 32-bit words from up to 8 first-word-fall-through (FWFT) source FIFOs (front-end receivers, TDC, trigger logic) into one FWFT stream.
- Sits directly upstream of the SRAM output FIFO: its OUT_EMPTY/OUT_DATA/OUT_READ connect to that block's FIFO_EMPTY_IN/FIFO_DATA/FIFO_READ_NEXT_OUT.
- A registered 2-entry output buffer breaks every combinational path from OUT_READ to SRC_READ.

Parameters:
- N_SRC, 4: number of sources, 1..8.

Ports:
- BUS_CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- SRC_EMPTY  input  N_SRC  per-source FWFT empty flag.
- SRC_DATA  input  32*N_SRC  per-source head word; source i occupies bits [32*i+31:32*i].
- SRC_READ  output  N_SRC  per-source pop strobe, at most one bit high per cycle.
- SRC_ENABLE  input  N_SRC  per-source enable mask; a disabled source is never granted.
- OUT_EMPTY  output  1  high when the output buffer holds no word.
- OUT_DATA  output  32  head word of the output buffer; valid whenever OUT_EMPTY=0.
- OUT_READ  input  1  pop strobe from the consumer.
- READ_ERROR_CNT  output  8  saturating count of OUT_READ pulses while OUT_EMPTY=1.

Behaviour:
- Reset values:
  - SRC_READ=0 (forced 0 while RST is high).
  - OUT_EMPTY=1, OUT_DATA=0, READ_ERROR_CNT=0.
  - Buffer count=0, last_grant=N_SRC-1, so source 0 has first priority.
- Output buffer: 2 entries with a 2-bit count (0..2), a 1-bit write pointer and a 1-bit read pointer.
  - OUT_DATA = entry[read pointer].
  - OUT_EMPTY = (count==0).
- Pop: OUT_READ && count!=0 advances the read pointer.
- Grant:
  - Each cycle, with a registered count<2, form candidates = ~SRC_EMPTY & SRC_ENABLE.
  - The grant is the first candidate searched cyclically from last_grant+1 (mod N_SRC).
  - If a grant exists: SRC_READ[grant]=1 combinationally that cycle, and SRC_DATA[grant] is written to entry[write pointer] on the edge.
  - On that same edge the write pointer advances and last_grant<=grant.
- No grant when count==2 or there are no candidates. SRC_READ=0 and last_grant holds.
- Simultaneous push and pop: count is unchanged. Sustained throughput is 1 word/cycle.
- Latency: a word at a source head with an empty buffer appears on OUT_DATA (OUT_EMPTY=0) one cycle after its SRC_READ cycle.
- Fairness:
  - One word per grant; the pointer always rotates.
  - With k sources continuously non-empty, each receives exactly 1 of every k grants.
- Wrap-around: the search wraps from N_SRC-1 to 0. With N_SRC=1 the arbiter degenerates to a 2-deep pass-through buffer.
- SRC_ENABLE deasserted mid-stream:
  - It takes effect on the next grant decision.
  - A word already in the buffer is still delivered.
- Read error:
  - OUT_READ while count==0 leaves the buffer unchanged.
  - READ_ERROR_CNT increments by one and saturates at 8'hFF.
- Reset mid-operation:
  - Buffered words are discarded with no further SRC_READ.
  - Counter and grant pointer return to their reset values on the edge where RST=1.
- Source pop rule: SRC_READ is never asserted to a source whose SRC_EMPTY=1 in the same cycle.

Optional Feature:
- Macro RR_ARB_SRC_TAG_EN.
- Defined: the stored word is {grant[2:0], SRC_DATA[28:0]}, i.e. bits 31:29 carry the source index.
- Undefined: the word is stored unmodified, with bits 31:29 passed through.

Test Plan:
- Reset, then src0 holds one word 32'h1234_5678, others empty.
  - Expect SRC_READ=4'b0001 for exactly 1 cycle.
  - One cycle later OUT_EMPTY=0 and OUT_DATA=32'h1234_5678; with the tag macro, OUT_DATA=32'h1234_5678 & 32'h1FFF_FFFF.
- All 4 sources continuously non-empty with distinct words, OUT_READ held high.
  - Expect grant order 0,1,2,3,0,1,...
  - 12 words delivered in 12 consecutive cycles, each source exactly 3 times.
- OUT_READ held low with sources non-empty.
  - Expect exactly 2 pops, then SRC_READ=0 and OUT_EMPTY=0.
  - Pulse OUT_READ once: expect exactly one further pop and the buffer refilled to 2.
- SRC_ENABLE=4'b1010 with all sources non-empty.
  - Expect grants to alternate 1,3,1,3 only.
  - SRC_READ[0] and SRC_READ[2] never asserted.
- 300 OUT_READ pulses with all sources empty.
  - Expect READ_ERROR_CNT to saturate at 8'hFF, OUT_EMPTY=1 throughout, SRC_READ=0.
- Assert RST for 1 cycle with the buffer holding 2 words.
  - Expect OUT_EMPTY=1 and READ_ERROR_CNT=0 the next cycle.
  - The next grant goes to source 0 if it is non-empty, regardless of the previous pointer.
